// File: rtl/lmsm_seq_engine.sv
// Load/store-multiple sequencer: walks reg_mask lowest-to-highest, one req/ack memory transfer per set bit.
// Optional LMSM_BACK_TO_BACK_EN keeps mem_req high between transfers (SCAN only once after start).
module lmsm_seq_engine #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 16,
  parameter  int NREGS  = 8,
  localparam int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_t;

  state_t             state;
  logic [NREGS-1:0]   mask_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [IDX_W-1:0]   idx_q;
  logic               store_q;
  logic [DATA_W-1:0]  wdata_q;

  logic [IDX_W-1:0]   scan_idx;
  logic               scan_any;
  logic [NREGS-1:0]   nxt_mask;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NREGS-1:0] m);
    lowest_set = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  always_comb begin
    scan_idx = lowest_set(mask_q);
    scan_any = |mask_q;
    nxt_mask = mask_q & ~(NREGS'(1) << idx_q);
  end

`ifdef LMSM_BACK_TO_BACK_EN
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_any;

  always_comb begin
    nxt_idx = lowest_set(nxt_mask);
    nxt_any = |nxt_mask;
  end

  // While a transfer is pending the RF already reads the following register.
  assign rf_raddr = (state == SCAN) ? scan_idx :
                    (state == REQ)  ? nxt_idx  : idx_q;
`else
  assign rf_raddr = (state == SCAN) ? scan_idx : idx_q;
`endif

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state   <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      store_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SCAN;
            mask_q  <= reg_mask;
            addr_q  <= base_addr;
            store_q <= is_store;
          end
        end
        SCAN: begin
          if (scan_any) begin
            state <= REQ;
            idx_q <= scan_idx;
            if (store_q) wdata_q <= rf_rdata;
          end else begin
            state <= DONE;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mask_q <= nxt_mask;
            addr_q <= addr_q + 1'b1;
`ifdef LMSM_BACK_TO_BACK_EN
            if (nxt_any) begin
              idx_q <= nxt_idx;
              if (store_q) wdata_q <= rf_rdata;
            end else begin
              state <= DONE;
            end
`else
            state <= SCAN;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state, so async reset clears them at once.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & store_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rf_we     = mem_req & mem_ack & ~store_q;
  assign rf_waddr  = idx_q;
  assign rf_wdata  = rf_we ? mem_rdata : '0;

endmodule
